ibex_cpi_snapshot_reader: RTL
=============================

IBEX_CPI_SNAPSHOT_READER -- requirements
Module: ibex_cpi_snapshot_reader

Interface
REQ-001 SHALL have parameter N_LANES, default 1, meaning number of datapath lanes whose CPI counters are read.
REQ-002 SHALL have parameter SAMPLE_PERIOD, default 1024, meaning cycles between automatic snapshots; 0 disables automatic snapshots.
REQ-003 SHALL have port clk_i  input  1  clock.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable_i  input  1  enables snapshot triggers and the period timer.
REQ-006 SHALL have port snap_req_i  input  1  single-cycle software/debug snapshot request.
REQ-007 SHALL have port cnt_i  input  N_LANES*7*32  live counters; per lane, in ascending index order: cycle, base, icache, bpred, dcache, ex, dependency; lane 0 occupies the least significant bits.
REQ-008 SHALL have port out_valid_o  output  1  frame word valid.
REQ-009 SHALL have port out_ready_i  input  1  sink accepts word.
REQ-010 SHALL have port out_data_o  output  32  frame word.
REQ-011 SHALL have port out_last_o  output  1  final word of frame.
REQ-012 SHALL have port busy_o  output  1  frame in progress.
REQ-013 SHALL have port drop_cnt_o  output  8  saturating count of triggers dropped while busy.

Function
REQ-014 Trigger SHALL be (snap_req_i OR period_hit) AND enable_i.
REQ-015 Period timer: while enable_i=1 and SAMPLE_PERIOD>0, counts 0..SAMPLE_PERIOD-1; period_hit asserts on the cycle it equals SAMPLE_PERIOD-1; it then wraps to 0; it holds its value while enable_i=0.
REQ-016 FSM states: IDLE, HDR, DATA.
REQ-017 IDLE: on trigger at edge t, all of cnt_i is copied into a shadow register, the state becomes HDR, and out_valid_o=1 from cycle t+1.
REQ-018 HDR word SHALL be {16'hC510, seq[7:0], N_LANES[7:0]}; on valid&ready, the state becomes DATA with word index 0.
REQ-019 DATA word k (0..7*N_LANES-1) SHALL be shadow counter k in cnt_i order; index advances only on valid&ready.
REQ-020 out_last_o SHALL be 1 exactly on word 7*N_LANES-1; on its handshake, the state becomes IDLE, seq increments modulo 256 and out_valid_o drops the next cycle.
REQ-021 While out_valid_o=1 and out_ready_i=0, out_data_o and out_last_o SHALL remain stable; out_valid_o SHALL NOT deassert before the handshake.
REQ-022 A trigger while state is not IDLE, including on the cycle of the last handshake, SHALL be dropped and SHALL increment drop_cnt_o, saturating at 255.
REQ-023 busy_o SHALL equal (state != IDLE).
REQ-024 Deasserting enable_i mid-frame SHALL NOT abort the frame; it completes normally.
REQ-025 snap_req_i and period_hit in the same cycle SHALL count as one trigger.
REQ-026 Changes on cnt_i after capture SHALL NOT affect the frame in flight.
REQ-027 Maximum throughput: one word per cycle with out_ready_i held high; frame length 1+7*N_LANES words.

Reset
REQ-028 Asynchronous reset SHALL force the state to IDLE, out_valid_o=0, out_last_o=0, out_data_o=0, busy_o=0, drop_cnt_o=0, seq=0, period timer=0 and the shadow register to 0.
REQ-029 Reset mid-frame SHALL abandon the frame without emitting a last word; the first frame after reset SHALL carry seq=0.

Structure
REQ-030 The shared tracer package SHALL hold CPI_NUM_CNT=7, CPI_FRAME_MAGIC=16'hC510, the counter-index enum (cycle..dependency) and the FSM state typedef.
REQ-031 The period timer SHALL be a single sub-module, ibex_cpi_period_timer (ports clk_i, rst_ni, en_i, hit_o); the serializer SHALL be inline.

Verification
REQ-032 N_LANES=1, ready=1, snap_req pulse with cnt_i={1..7}: the frame SHALL be 32'hC5100001, 1,2,3,4,5,6,7, with last on 7; valid SHALL assert one cycle after the request.
REQ-033 Ready toggling 1-0-1 during DATA: no word lost or duplicated, and out_data_o SHALL be held during stalls.
REQ-034 SAMPLE_PERIOD=16, enable held for 64 cycles, ready=1: four frames with seq 0,1,2,3, spaced 16 cycles apart.
REQ-035 Three snap_req pulses during one frame: drop_cnt_o=3; with 300 drops, drop_cnt_o=255.
REQ-036 N_LANES=2: the frame SHALL be 15 words with header low byte 8'h02, lane 1 counters at words 8..14.
REQ-037 rst_ni asserted at DATA word 3, then released, then a request: out_valid_o SHALL be 0 during reset, and the new header SHALL carry seq 0.

Source files
------------

// File: rtl/ibex_cpi_snapshot_reader_pkg.sv
// Shared tracer definitions for the CPI snapshot reader: counter layout,
// frame header magic and serializer state encoding.
package ibex_cpi_snapshot_reader_pkg;

    localparam int unsigned CPI_NUM_CNT     = 7;
    localparam logic [15:0] CPI_FRAME_MAGIC = 16'hC510;

    // Per-lane counter order as laid out on cnt_i (ascending bit position).
    typedef enum logic [2:0] {
        CPI_CNT_CYCLE      = 3'd0,
        CPI_CNT_BASE       = 3'd1,
        CPI_CNT_ICACHE     = 3'd2,
        CPI_CNT_BPRED      = 3'd3,
        CPI_CNT_DCACHE     = 3'd4,
        CPI_CNT_EX         = 3'd5,
        CPI_CNT_DEPENDENCY = 3'd6
    } cpi_cnt_idx_e;

    typedef enum logic [1:0] {
        CPI_IDLE = 2'd0,
        CPI_HDR  = 2'd1,
        CPI_DATA = 2'd2
    } cpi_state_e;

    function automatic logic [31:0] cpi_header(input logic [7:0] seq, input logic [7:0] lanes);
        return {CPI_FRAME_MAGIC, seq, lanes};
    endfunction

endpackage

// File: rtl/ibex_cpi_snapshot_reader_period_timer.sv
// Free-running sample period timer; pauses while disabled, SAMPLE_PERIOD=0
// never produces a hit.
module ibex_cpi_period_timer #(
    parameter int unsigned SAMPLE_PERIOD = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic hit_o
);

    localparam int unsigned CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'((SAMPLE_PERIOD == 0) ? 0 : SAMPLE_PERIOD - 1);
    localparam logic PERIOD_ON = (SAMPLE_PERIOD != 0);

    logic [CW-1:0] cnt_q;

    assign hit_o = PERIOD_ON && en_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (en_i && PERIOD_ON) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ibex_cpi_snapshot_reader.sv
// Captures all lanes' CPI counters on a trigger and streams them out as one
// valid/ready frame: header word followed by 7*N_LANES counter words.
module ibex_cpi_snapshot_reader
    import ibex_cpi_snapshot_reader_pkg::*;
#(
    parameter int unsigned N_LANES       = 1,
    parameter int unsigned SAMPLE_PERIOD = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic                      snap_req_i,
    input  logic [N_LANES*7*32-1:0]   cnt_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [31:0]               out_data_o,
    output logic                      out_last_o,
    output logic                      busy_o,
    output logic [7:0]                drop_cnt_o
);

    localparam int unsigned NW = CPI_NUM_CNT * N_LANES;
    localparam int unsigned IW = $clog2(NW);
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);
    localparam logic [7:0] LANES_B = 8'(N_LANES);

    cpi_state_e    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    seq_q, seq_d;
    logic [7:0]    drop_q, drop_d;
    logic [31:0]   shadow_q [NW];
    logic          capture;
    logic          period_hit;
    logic          trigger;

    ibex_cpi_period_timer #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_period_timer (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .en_i  (enable_i),
        .hit_o (period_hit)
    );

    assign trigger = (snap_req_i | period_hit) & enable_i;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        seq_d       = seq_q;
        drop_d      = drop_q;
        capture     = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        out_data_o  = '0;

        case (state_q)
            CPI_IDLE: begin
                if (trigger) begin
                    capture = 1'b1;
                    state_d = CPI_HDR;
                end
            end
            CPI_HDR: begin
                out_valid_o = 1'b1;
                out_data_o  = cpi_header(seq_q, LANES_B);
                if (out_ready_i) begin
                    state_d = CPI_DATA;
                    idx_d   = '0;
                end
            end
            CPI_DATA: begin
                out_valid_o = 1'b1;
                out_data_o  = shadow_q[idx_q];
                out_last_o  = (idx_q == LAST_IDX);
                if (out_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = CPI_IDLE;
                        seq_d   = seq_q + 8'd1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = CPI_IDLE;
        endcase

        // Any trigger outside IDLE is lost, including on the final handshake.
        if (trigger && (state_q != CPI_IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    assign busy_o     = (state_q != CPI_IDLE);
    assign drop_cnt_o = drop_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CPI_IDLE;
            idx_q   <= '0;
            seq_q   <= '0;
            drop_q  <= '0;
            for (int unsigned i = 0; i < NW; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            if (capture) begin
                for (int unsigned i = 0; i < NW; i++) begin
                    shadow_q[i] <= cnt_i[32*i +: 32];
                end
            end
        end
    end

endmodule
